// File: rtl/booth_pkg.sv
// Shared types and constants for the booth multiplier / product accumulator pair.
package booth_pkg;

  localparam int PROD_W    = 32;
  localparam int OPERAND_W = 16;

  typedef enum logic {ACCUM, DONE} acc_state_t;

  typedef logic signed [PROD_W-1:0] product_t;

endpackage

// File: rtl/booth_product_accumulator_if.sv
// Product-in / result-out handshake bundle between multiplier, accumulator and consumer.
interface booth_product_accumulator_if #(
  parameter int PROD_W = 32,
  parameter int OUT_W  = 32,
  parameter int CNT_W  = 4
);

  logic signed [PROD_W-1:0] prod_in;
  logic                     prod_valid;
  logic                     prod_ready;
  logic                     clear;
  logic [OUT_W-1:0]         acc_out;
  logic                     acc_valid;
  logic                     acc_ack;
  logic [CNT_W-1:0]         term_cnt;
  logic                     overflow;

  modport slave (
    input  prod_in, prod_valid, clear, acc_ack,
    output prod_ready, acc_out, acc_valid, term_cnt, overflow
  );

  modport master (
    output prod_in, prod_valid, clear, acc_ack,
    input  prod_ready, acc_out, acc_valid, term_cnt, overflow
  );

endinterface

// File: rtl/acc_saturate.sv
// Combinational clamp of a wide signed accumulator into a narrower signed result.
module acc_saturate #(
  parameter int ACC_W = 40,
  parameter int OUT_W = 32
) (
  input  logic signed [ACC_W-1:0] acc_in,
  output logic [OUT_W-1:0]        sat_out,
  output logic                    overflow
);

  // Value fits iff every bit from the result sign bit upward is identical.
  logic [ACC_W-OUT_W:0] upper;
  assign upper = acc_in[ACC_W-1:OUT_W-1];

  always_comb begin
    overflow = !((&upper) || !(|upper));
    sat_out  = acc_in[OUT_W-1:0];
    if (overflow) begin
      sat_out = acc_in[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                : {1'b0, {(OUT_W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/booth_product_accumulator.sv
// Sums N_TERMS signed products per result and hands it off via valid/ack.
// Define BOOTH_ACC_SAT_EN to saturate out-of-range results and flag overflow.
module booth_product_accumulator #(
  parameter int PROD_W  = booth_pkg::PROD_W,
  parameter int N_TERMS = 8,
  parameter int ACC_W   = 40,
  parameter int OUT_W   = 32
) (
  input logic                      clk,
  input logic                      rst,
  booth_product_accumulator_if.slave bus
);
  import booth_pkg::*;

  localparam int CNT_W = $clog2(N_TERMS) + 1;

  generate
    if (ACC_W < PROD_W + $clog2(N_TERMS) || OUT_W > ACC_W || N_TERMS < 2 || N_TERMS > 256) begin : g_bad_params
      $error("booth_product_accumulator: illegal parameter combination");
    end
  endgenerate

  acc_state_t               state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [OUT_W-1:0]         acc_out_q, acc_out_d;
  logic                     acc_valid_q, acc_valid_d;
  logic                     overflow_q, overflow_d;
  logic                     prod_ready_q, prod_ready_d;

  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  acc_sum;
  logic [OUT_W-1:0]         conv_out;
  logic                     conv_ovf;
  logic                     accept;

  assign prod_ext = {{(ACC_W-PROD_W){bus.prod_in[PROD_W-1]}}, bus.prod_in};
  assign acc_sum  = acc_q + prod_ext;
  assign accept   = bus.prod_valid && prod_ready_q && (state_q == ACCUM);

`ifdef BOOTH_ACC_SAT_EN
  acc_saturate #(
    .ACC_W (ACC_W),
    .OUT_W (OUT_W)
  ) u_sat (
    .acc_in   (acc_sum),
    .sat_out  (conv_out),
    .overflow (conv_ovf)
  );
`else
  assign conv_out = acc_sum[OUT_W-1:0];
  assign conv_ovf = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    acc_out_d   = acc_out_q;
    acc_valid_d = acc_valid_q;
    overflow_d  = overflow_q;
    if (bus.clear) begin
      // Abort wins over everything, including a product offered this cycle.
      state_d     = ACCUM;
      acc_d       = '0;
      cnt_d       = '0;
      acc_valid_d = 1'b0;
      overflow_d  = 1'b0;
    end else if (state_q == ACCUM) begin
      if (accept) begin
        acc_d = acc_sum;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(N_TERMS - 1)) begin
          state_d     = DONE;
          acc_out_d   = conv_out;
          overflow_d  = conv_ovf;
          acc_valid_d = 1'b1;
        end
      end
    end else if (bus.acc_ack) begin
      state_d     = ACCUM;
      acc_d       = '0;
      cnt_d       = '0;
      acc_valid_d = 1'b0;
      overflow_d  = 1'b0;
    end
    prod_ready_d = (state_d == ACCUM);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ACCUM;
      acc_q        <= '0;
      cnt_q        <= '0;
      acc_out_q    <= '0;
      acc_valid_q  <= 1'b0;
      overflow_q   <= 1'b0;
      prod_ready_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      acc_out_q    <= acc_out_d;
      acc_valid_q  <= acc_valid_d;
      overflow_q   <= overflow_d;
      prod_ready_q <= prod_ready_d;
    end
  end

  assign bus.prod_ready = prod_ready_q;
  assign bus.acc_out    = acc_out_q;
  assign bus.acc_valid  = acc_valid_q;
  assign bus.term_cnt   = cnt_q;
  assign bus.overflow   = overflow_q;

endmodule
